// File: rtl/aes_inv_subbytes_iter_pkg.sv
// Shared AES definitions: state width, FSM encoding, LANES legality and the
// GF(2^8) arithmetic used by the S-box lanes.
package aes_inv_subbytes_iter_pkg;

  localparam int unsigned STATE_W   = 128;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_BYTES = STATE_W / BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic bit lanes_legal(input int unsigned lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 16);
  endfunction

  // Lane counter width, never below one bit even when a single pass suffices.
  function automatic int unsigned cnt_width(input int unsigned lanes);
    return (NUM_BYTES / lanes <= 1) ? 1 : $clog2(NUM_BYTES / lanes);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  // x^254 = x^-1 in GF(2^8) mod x^8+x^4+x^3+x+1; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse of the forward affine map; bit 0 is the LSB as in the forward box.
  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    logic [7:0] y;
    for (int unsigned i = 0; i < 8; i++) begin
      y[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
    end
    return y ^ 8'h05;
  endfunction

endpackage

// File: rtl/aes_inv_subbytes_iter_sbox.sv
// Unmasked combinational AES inverse S-box: inverse affine, then GF(2^8) inversion.
module sbox_inv_bp_umsk
  import aes_inv_subbytes_iter_pkg::*;
(
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  logic [7:0] w_aff;

  assign w_aff  = inv_affine(i_data);
  assign o_data = gf_inv(w_aff);

endmodule

// File: rtl/aes_inv_subbytes_iter.sv
// Iterative InvSubBytes: LANES inverse S-boxes sweep the 128-bit state,
// LANES bytes per cycle, with a valid/ready handshake on both sides.
module aes_inv_subbytes_iter
  import aes_inv_subbytes_iter_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
);

  localparam int unsigned STEPS = NUM_BYTES / LANES;
  localparam int unsigned CNT_W = cnt_width(LANES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  generate
    if (!lanes_legal(LANES)) begin : g_bad_lanes
      $error("aes_inv_subbytes_iter: LANES must be 1, 2, 4 or 16");
    end
  endgenerate

  state_e             r_fsm;
  state_e             w_fsm_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [7:0]         w_lane_in  [LANES];
  logic [7:0]         w_lane_out [LANES];

  // Lane g works on byte LANES*cnt+g of the state register.
  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign w_lane_in[g] = r_state[BYTE_W*(LANES*32'(r_cnt) + 32'(g)) +: BYTE_W];

      sbox_inv_bp_umsk u_sbox (
        .i_data (w_lane_in[g]),
        .o_data (w_lane_out[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= ST_IDLE;
      r_cnt   <= '0;
      r_state <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    case (r_fsm)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt = in_data;
          w_cnt_nxt   = '0;
          w_fsm_nxt   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          w_state_nxt[BYTE_W*(LANES*32'(r_cnt) + l) +: BYTE_W] = w_lane_out[l];
        end
        w_cnt_nxt = r_cnt + CNT_W'(1);
        // Last slice written: stop here rather than wrap into another pass.
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          w_fsm_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) w_fsm_nxt = ST_IDLE;
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  // Handshake flags come from the state register; reset masks acceptance.
  assign in_ready  = (r_fsm == ST_IDLE) && !rst;
  assign out_valid = (r_fsm == ST_DONE);
  assign out_data  = r_state;

endmodule
